// File: rtl/mem_arbiter_if.sv
// IF/MEM request ports and byte-wide RAM port of the memory arbiter.
// slave = arbiter side, master = CPU stages and RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic [31:0]       if_data;
  logic              if_done;
  logic              if_stall_req;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_width;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              mem_stall_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_width,
    input  mem_addr, mem_wdata, ram_din,
    output if_data, if_done, if_stall_req,
    output mem_rdata, mem_done, mem_stall_req,
    output ram_addr, ram_we, ram_dout
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_width,
    output mem_addr, mem_wdata, ram_din,
    input  if_data, if_done, if_stall_req,
    input  mem_rdata, mem_done, mem_stall_req,
    input  ram_addr, ram_we, ram_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter: MEM over IF priority, little-endian
// reassembly of 1/2/4-byte requests on a synchronous-read RAM.
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, IF_RD, MEM_RD, MEM_WR, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [2:0]        n, n_nxt;
  logic [2:0]        mem_n;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic [31:0]       rbuf, rbuf_nxt, rbuf_cap;
  logic [31:0]       if_data, if_data_nxt;
  logic [31:0]       mem_rdata, mem_rdata_nxt;
  logic              if_done, if_done_nxt;
  logic              mem_done, mem_done_nxt;
  logic [ADDR_W-1:0] ram_addr, ram_addr_nxt;
  logic              ram_we, ram_we_nxt;
  logic [7:0]        ram_dout, ram_dout_nxt;
  logic [1:0]        lane;
  logic              unused_addr;

  assign unused_addr = ^{bus.if_addr[31:ADDR_W],
                         bus.mem_addr[31:ADDR_W]};

  always_comb begin
    mem_n = 3'd4;
    unique case (1'b1)
      bus.mem_width == 2'b00: mem_n = 3'd1;
      bus.mem_width == 2'b01: mem_n = 3'd2;
      default:                mem_n = 3'd4;
    endcase
  end

  // cnt counts addresses issued; RAM data for
  // byte k is sampled two edges after issue
  assign lane = cnt[1:0] - 2'd2;

  always_comb begin
    rbuf_cap = rbuf;
    rbuf_cap[{lane, 3'b000} +: 8] = bus.ram_din;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    n_nxt         = n;
    base_nxt      = base;
    wdata_nxt     = wdata;
    rbuf_nxt      = rbuf;
    if_data_nxt   = if_data;
    mem_rdata_nxt = mem_rdata;
    if_done_nxt   = 1'b0;
    mem_done_nxt  = 1'b0;
    ram_addr_nxt  = ram_addr;
    ram_we_nxt    = ram_we;
    ram_dout_nxt  = ram_dout;
    unique case (state)
      IDLE: begin
        cnt_nxt = 3'd0;
        if (bus.mem_req) begin
          base_nxt     = bus.mem_addr[ADDR_W-1:0];
          n_nxt        = mem_n;
          wdata_nxt    = bus.mem_wdata;
          rbuf_nxt     = '0;
          cnt_nxt      = 3'd1;
          ram_addr_nxt = bus.mem_addr[ADDR_W-1:0];
          ram_we_nxt   = bus.mem_we;
          if (bus.mem_we) begin
            ram_dout_nxt = bus.mem_wdata[7:0];
            state_nxt    = MEM_WR;
          end else begin
            state_nxt    = MEM_RD;
          end
        end else if (bus.if_req) begin
          base_nxt     = bus.if_addr[ADDR_W-1:0];
          n_nxt        = 3'd4;
          rbuf_nxt     = '0;
          cnt_nxt      = 3'd1;
          ram_addr_nxt = bus.if_addr[ADDR_W-1:0];
          ram_we_nxt   = 1'b0;
          state_nxt    = IF_RD;
        end
      end
      IF_RD, MEM_RD: begin
        if (state == IF_RD && bus.if_flush) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
          if (cnt < n)
            ram_addr_nxt = base + ADDR_W'(cnt);
          if (cnt >= 3'd2)
            rbuf_nxt = rbuf_cap;
          if (cnt == n + 3'd1) begin
            state_nxt = DONE;
            cnt_nxt   = 3'd0;
            if (state == IF_RD) begin
              if_done_nxt = 1'b1;
              if_data_nxt = rbuf_cap;
            end else begin
              mem_done_nxt  = 1'b1;
              mem_rdata_nxt = rbuf_cap;
            end
          end
        end
      end
      MEM_WR: begin
        if (cnt < n) begin
          ram_addr_nxt = base + ADDR_W'(cnt);
          ram_dout_nxt = wdata[{cnt[1:0], 3'b000} +: 8];
          cnt_nxt      = cnt + 3'd1;
        end else begin
          ram_we_nxt   = 1'b0;
          mem_done_nxt = 1'b1;
          cnt_nxt      = 3'd0;
          state_nxt    = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      n         <= '0;
      base      <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_dout  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      n         <= n_nxt;
      base      <= base_nxt;
      wdata     <= wdata_nxt;
      rbuf      <= rbuf_nxt;
      if_data   <= if_data_nxt;
      mem_rdata <= mem_rdata_nxt;
      if_done   <= if_done_nxt;
      mem_done  <= mem_done_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_we    <= ram_we_nxt;
      ram_dout  <= ram_dout_nxt;
    end
  end

  assign bus.if_data       = if_data;
  assign bus.if_done       = if_done;
  assign bus.mem_rdata     = mem_rdata;
  assign bus.mem_done      = mem_done;
  assign bus.ram_addr      = ram_addr;
  assign bus.ram_we        = ram_we;
  assign bus.ram_dout      = ram_dout;
  assign bus.if_stall_req  = bus.if_req & ~if_done;
  assign bus.mem_stall_req = bus.mem_req & ~mem_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte-wide
// synchronous-read RAM model.
module tb_mem_arbiter;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] exp_if[$];
  logic [31:0] exp_mem[$];
  logic [7:0]  ram [0:(1<<AW)-1];

  mem_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we)
      ram[bus.ram_addr] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.if_done) begin
      if (exp_if.size() == 0)
        chk("if_done_unexpected", 32'd1, 32'd0);
      else
        chk("if_data", bus.if_data, exp_if.pop_front());
    end
    if (bus.mem_done && !bus.mem_we) begin
      if (exp_mem.size() == 0)
        chk("mem_done_unexpected", 32'd1, 32'd0);
      else
        chk("mem_rdata", bus.mem_rdata, exp_mem.pop_front());
    end
  end

  task automatic wait_done(input bit want_if,
                           output int cyc);
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      seen = want_if ? bus.if_done : bus.mem_done;
    end
    if (!seen)
      chk(want_if ? "if_timeout" : "mem_timeout",
          32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
    chk({tag, "_ram_dout"}, 32'(bus.ram_dout), 32'd0);
    chk({tag, "_if_done"}, 32'(bus.if_done), 32'd0);
    chk({tag, "_mem_done"}, 32'(bus.mem_done), 32'd0);
    chk({tag, "_if_data"}, bus.if_data, 32'd0);
    chk({tag, "_mem_rdata"}, bus.mem_rdata, 32'd0);
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    ram[a] <= v;
  endtask

  initial begin
    int c;
    int mem_done_cyc;
    int if_addr_cyc;
    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_width = 2'b00;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    poke('h100, 8'h13); poke('h101, 8'h05);
    poke('h102, 8'h00); poke('h103, 8'h00);
    poke('h104, 8'h93); poke('h105, 8'h00);
    poke('h106, 8'h10); poke('h107, 8'h00);
    poke('h200, 8'h11); poke('h201, 8'h22);
    poke('h202, 8'h33); poke('h203, 8'h44);
    poke('h1FFFF, 8'h00); poke('h0, 8'h5A);
    poke('h1, 8'h77);
    poke('h300, 8'h80); poke('h301, 8'hFF);
    poke('h400, 8'h01); poke('h401, 8'h02);
    poke('h402, 8'h03); poke('h403, 8'h04);
    for (int i = 0; i < 4; i++) poke('h500 + i, 8'hEE);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // word fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    exp_if.push_back(32'h0000_0513);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fetch_addr", 32'(bus.ram_addr), 32'h100 + k);
      chk("fetch_we", 32'(bus.ram_we), 32'd0);
    end
    chk("fetch_stall_busy", 32'(bus.if_stall_req), 32'd1);
    wait_done(1'b1, c);
    chk("fetch_latency", c, 32'd2);
    chk("fetch_stall_done", 32'(bus.if_stall_req), 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("fetch_done_pulse", 32'(bus.if_done), 32'd0);
    chk("fetch_data_hold", bus.if_data, 32'h0000_0513);

    // simultaneous IF and MEM load
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h104;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_width = 2'b10;
    bus.mem_addr  = 32'h200;
    exp_mem.push_back(32'h4433_2211);
    exp_if.push_back(32'h0010_0093);
    mem_done_cyc = 0;
    if_addr_cyc  = 0;
    c = 0;
    while (bus.if_req && c < 60) begin
      @(negedge clk);
      c++;
      if (bus.mem_done && mem_done_cyc == 0) begin
        mem_done_cyc = c;
        bus.mem_req  = 1'b0;
      end
      if (bus.ram_addr == AW'('h104) && if_addr_cyc == 0)
        if_addr_cyc = c;
      if (bus.if_done)
        bus.if_req = 1'b0;
    end
    chk("simul_finished", 32'(bus.if_req), 32'd0);
    chk("simul_mem_done_cyc", mem_done_cyc, 32'd6);
    chk("simul_if_gap", if_addr_cyc, mem_done_cyc + 2);
    @(negedge clk);

    // store half across the address wrap
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_width = 2'b01;
    bus.mem_addr  = 32'h0001_FFFF;
    bus.mem_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk("st_we0", 32'(bus.ram_we), 32'd1);
    chk("st_addr0", 32'(bus.ram_addr), 32'h1FFFF);
    chk("st_dout0", 32'(bus.ram_dout), 32'hDD);
    @(negedge clk);
    chk("st_addr1", 32'(bus.ram_addr), 32'h0);
    chk("st_dout1", 32'(bus.ram_dout), 32'hCC);
    @(negedge clk);
    chk("st_done", 32'(bus.mem_done), 32'd1);
    chk("st_we_off", 32'(bus.ram_we), 32'd0);
    bus.mem_req = 1'b0;
    @(negedge clk);
    chk("st_done_pulse", 32'(bus.mem_done), 32'd0);
    chk("st_we_low", 32'(bus.ram_we), 32'd0);
    chk("st_ram_1ffff", 32'(ram['h1FFFF]), 32'hDD);
    chk("st_ram_0", 32'(ram['h0]), 32'hCC);
    chk("st_ram_1", 32'(ram['h1]), 32'h77);

    // load byte, upper lanes zero
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_width = 2'b00;
    bus.mem_addr  = 32'h300;
    exp_mem.push_back(32'h0000_0080);
    wait_done(1'b0, c);
    chk("ldb_latency", c, 32'd3);
    bus.mem_req = 1'b0;
    @(negedge clk);

    // flush at cnt=2 with a pending load
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    bus.if_flush  = 1'b1;
    bus.if_req    = 1'b0;
    bus.mem_req   = 1'b1;
    bus.mem_width = 2'b11;
    bus.mem_addr  = 32'h200;
    exp_mem.push_back(32'h4433_2211);
    @(negedge clk);
    bus.if_flush = 1'b0;
    chk("flush_no_done", 32'(bus.if_done), 32'd0);
    chk("flush_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    chk("flush_mem_addr", 32'(bus.ram_addr), 32'h200);
    wait_done(1'b0, c);
    bus.mem_req = 1'b0;
    chk("flush_if_hold", bus.if_data, 32'h0010_0093);
    @(negedge clk);

    // reset after byte 1 of a word store
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_width = 2'b10;
    bus.mem_addr  = 32'h500;
    bus.mem_wdata = 32'h8765_4321;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("rst_mid");
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ram_500", 32'(ram['h500]), 32'h21);
    chk("rst_ram_501", 32'(ram['h501]), 32'h43);
    chk("rst_ram_502", 32'(ram['h502]), 32'hEE);
    chk("rst_ram_503", 32'(ram['h503]), 32'hEE);
    chk("sb_if_empty", exp_if.size(), 32'd0);
    chk("sb_mem_empty", exp_mem.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
